// File: rtl/mem_wb_buff.sv
// Two-entry elastic receive buffer between EX/MEM and MEM/WB.
// Head/skid registers give one cycle of stall absorption with no ready path from out_ready to in_ready.
module mem_wb_buff #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_bus,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [CNTW-1:0]  xfer_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] skid_r;
  logic [1:0]       count_r;
  logic [CNTW-1:0]  xfer_r;

  logic [WIDTH-1:0] head_nxt_s;
  logic [WIDTH-1:0] skid_nxt_s;
  logic [1:0]       count_nxt_s;
  logic [CNTW-1:0]  xfer_nxt_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  // State register: occupancy, storage and delivered-word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {WIDTH{1'b0}};
      skid_r  <= {WIDTH{1'b0}};
      count_r <= ST_EMPTY;
      xfer_r  <= {CNTW{1'b0}};
    end else begin
      head_r  <= head_nxt_s;
      skid_r  <= skid_nxt_s;
      count_r <= count_nxt_s;
      xfer_r  <= xfer_nxt_s;
    end
  end

  // Next-state logic; flush only clears occupancy, the counter keeps running
  always_comb begin
    head_nxt_s  = head_r;
    skid_nxt_s  = skid_r;
    count_nxt_s = count_r;
    if (pop_s) begin
      xfer_nxt_s = xfer_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      xfer_nxt_s = xfer_r;
    end
    if (flush) begin
      count_nxt_s = ST_EMPTY;
    end else begin
      case (count_r)
        ST_EMPTY: begin
          if (push_s) begin
            head_nxt_s  = data_in_bus;
            count_nxt_s = ST_ONE;
          end else begin
            count_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_nxt_s = data_in_bus;
          end else if (push_s) begin
            skid_nxt_s  = data_in_bus;
            count_nxt_s = ST_FULL;
          end else if (pop_s) begin
            count_nxt_s = ST_EMPTY;
          end else begin
            count_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            head_nxt_s  = skid_r;
            count_nxt_s = ST_ONE;
          end else begin
            count_nxt_s = ST_FULL;
          end
        end
        default: begin
          count_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs: gated by flush and reset, never by out_ready
  always_comb begin
    if (rst && (count_r != ST_FULL) && !flush) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    if ((count_r != ST_EMPTY) && !flush) begin
      out_valid_s = 1'b1;
    end else begin
      out_valid_s = 1'b0;
    end
    push_s = in_valid && in_ready_s;
    pop_s  = out_valid_s && out_ready;
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_s;
  assign data_out_bus = head_r;
  assign count        = count_r;
  assign xfer_cnt     = xfer_r;

endmodule

// File: tb/tb_mem_wb_buff.sv
// Self-checking bench for mem_wb_buff: directed vector table, hand sequences
// and randomized traffic compared against a queue-based reference model.
module tb_mem_wb_buff;

  logic        clk;
  logic        rst;
  logic [15:0] data_in_bus;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] data_out_bus;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  count;
  logic [7:0]  xfer_cnt;

  mem_wb_buff #(.WIDTH(16), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .data_in_bus(data_in_bus), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .data_out_bus(data_out_bus),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: words held in arrival order plus a delivered-word count
  logic [15:0] mq[$];
  logic [7:0]  m_xfer = 8'd0;
  logic        m_push, m_pop, m_fl;
  logic [15:0] m_d;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        fl;
    logic        ordy;
    logic [1:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_dout;
    logic [7:0]  e_xfer;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive inputs just after a rising edge, compare against the model at the falling edge
  task automatic drive_check(input logic iv, input logic [15:0] d, input logic fl, input logic ordy);
    int n;
    logic ov, ir;
    in_valid = iv; data_in_bus = d; flush = fl; out_ready = ordy;
    @(negedge clk);
    n  = mq.size();
    ov = (n != 0) && !fl;
    ir = (n < 2) && !fl;
    chk("count", {30'd0, count}, n);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, ir});
    chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, m_xfer});
    if (ov) chk("data_out", {16'd0, data_out_bus}, {16'd0, mq[0]});
    m_push = iv && ir;
    m_pop  = ov && ordy;
    m_fl   = fl;
    m_d    = d;
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_fl) begin
      mq.delete();
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        m_xfer = m_xfer + 8'd1;
      end
      if (m_push) mq.push_back(m_d);
    end
    #1;
  endtask

  task automatic step(input logic iv, input logic [15:0] d, input logic fl, input logic ordy);
    drive_check(iv, d, fl, ordy);
    advance();
  endtask

  initial begin
    logic [7:0] xs;
    int guard;
    //        iv   d        fl    ordy  cnt   ov    ir    dout      xfer
    tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd0};
    tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h1111, 8'd0};
    tbl[2]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 16'h1111, 8'd0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 16'h1111, 8'd0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h2222, 8'd1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2};
    tbl[6]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2};
    tbl[7]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h3333, 8'd2};
    tbl[8]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0000, 8'd2};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2};
    tbl[10] = '{1'b1, 16'h6666, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd2};
    tbl[11] = '{1'b1, 16'h7777, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h6666, 8'd2};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h7777, 8'd3};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h0000, 8'd4};

    // reset held with a word offered: nothing may be accepted
    rst = 1'b0; in_valid = 1'b1; data_in_bus = 16'hABCD; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_data_out", {16'd0, data_out_bus}, 32'd0);
    chk("rst_xfer", {24'd0, xfer_cnt}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_count", {30'd0, count}, 32'd0);

    // directed vector table: stall/skid, flush with in_valid, push&pop in ONE
    for (int i = 0; i < 14; i++) begin
      drive_check(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i), {30'd0, count}, {30'd0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_ir", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_xfer", i), {24'd0, xfer_cnt}, {24'd0, tbl[i].e_xfer});
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_dout", i), {16'd0, data_out_bus}, {16'd0, tbl[i].e_dout});
      advance();
    end

    // streaming 16 words back to back
    xs = m_xfer;
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("stream_xfer", {24'd0, xfer_cnt}, {24'd0, xs + 8'd16});
    chk("stream_empty", {30'd0, count}, 32'd0);

    // counter wrap
    guard = 0;
    while (m_xfer != 8'd0 && guard < 600) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_to_0", {24'd0, xfer_cnt}, 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("wrap_to_1", {24'd0, xfer_cnt}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    // asynchronous reset in the middle of a stall
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b0);
    chk("pre_areset_count", {30'd0, count}, 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("areset_count", {30'd0, count}, 32'd0);
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_xfer", {24'd0, xfer_cnt}, 32'd0);
    chk("areset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("areset_data_out", {16'd0, data_out_bus}, 32'd0);
    mq.delete();
    m_xfer = 8'd0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
